// File: rtl/game2048_pkg.sv
// Shared types and sizes for the 2048 move sequencer and its spawn picker.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package game2048_pkg;

    localparam int BOARD_N = 4;
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int POS_W   = 4;
    localparam int TILE_W  = 12;
    localparam int SCORE_W = 20;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        GS_PLAYING = 2'd0,
        GS_WON     = 2'd1,
        GS_LOST    = 2'd2
    } gstate_e;

    // Button bit index equals the command encoding; only called on one-hot input.
    function automatic dir_e onehot_to_dir(input logic [3:0] btn);
        dir_e d;
        case (btn)
            4'b0010: d = DIR_DOWN;
            4'b0100: d = DIR_LEFT;
            4'b1000: d = DIR_RIGHT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/game2048_spawn_pick.sv
// Picks the cell and value for a new tile from the LFSR and the empty-cell mask.
// Latency: purely combinational.
// Backpressure: none; caller registers the result while its request is pending.
// Ports: lfsr_i (low LFSR byte: [3:0] scan start, [7:4] value select), empty_mask_i (bit r*4+c),
//        pos_o (chosen cell), val_o (2 or 4), none_o (board full, no pick).
module game2048_spawn_pick
    import game2048_pkg::*;
(
    input  logic [7:0]        lfsr_i,
    input  logic [CELLS-1:0]  empty_mask_i,
    output logic [POS_W-1:0]  pos_o,
    output logic [TILE_W-1:0] val_o,
    output logic              none_o
);

    logic [POS_W-1:0] start;
    logic [POS_W-1:0] offs;
    logic [CELLS-1:0] rot;

    always_comb begin
        start = lfsr_i[3:0];
        // Rotate so the scan start lands on bit 0; the lowest set bit is then the first
        // empty cell met scanning start, start+1, ... with wrap-around.
        rot   = CELLS'({empty_mask_i, empty_mask_i} >> start);
        offs  = '0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = POS_W'(i);
            end
        end
        pos_o  = start + offs;
        none_o = (empty_mask_i == '0);
        val_o  = (lfsr_i[7:4] == 4'd0) ? TILE_W'(4) : TILE_W'(2);
    end

endmodule

// File: rtl/game2048_move_ctrl.sv
// Move sequencer: one move per button press, then score, tile spawn and win/lose evaluation.
// Latency: press sampled at edge N -> move_valid after edge N; spawn_req >= 1 cycle after move_done.
// Backpressure: move_valid/move_dir held until move_ready; spawn_req/pos/val held until spawn_ack.
// Ports: clk, rst (async active-low); direction (one-hot buttons); move_valid/move_dir/move_ready
//        command handshake; move_done/board_changed/merge_score move result; empty_mask/max_tile/
//        can_merge board flags; spawn_req/spawn_pos/spawn_val/spawn_ack tile write; score,
//        game_state, busy status.
module game2048_move_ctrl
    import game2048_pkg::*;
#(
    parameter logic [TILE_W-1:0] WIN_TILE   = 12'd2048,
    parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
    parameter int unsigned       INIT_TILES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          direction,
    output logic                move_valid,
    output logic [1:0]          move_dir,
    input  logic                move_ready,
    input  logic                move_done,
    input  logic                board_changed,
    input  logic [TILE_W-1:0]   merge_score,
    input  logic [CELLS-1:0]    empty_mask,
    input  logic [TILE_W-1:0]   max_tile,
    input  logic                can_merge,
    output logic                spawn_req,
    output logic [POS_W-1:0]    spawn_pos,
    output logic [TILE_W-1:0]   spawn_val,
    input  logic                spawn_ack,
    output logic [SCORE_W-1:0]  score,
    output logic [1:0]          game_state,
    output logic                busy
);

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_ISSUE, ST_WAIT, ST_SPAWN, ST_SREQ, ST_CHECK, ST_WON, ST_LOST
    } state_e;

    localparam logic [7:0] INIT_LIM = 8'(INIT_TILES);

    state_e              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [3:0]          dir_prev_q;
    logic [7:0]          init_cnt_q, init_cnt_d;
    logic                from_init_q, from_init_d;
    logic                move_valid_q, move_valid_d;
    dir_e                move_dir_q, move_dir_d;
    logic                spawn_req_q, spawn_req_d;
    logic [POS_W-1:0]    spawn_pos_q, spawn_pos_d;
    logic [TILE_W-1:0]   spawn_val_q, spawn_val_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    gstate_e             gstate_q, gstate_d;
    logic                busy_q, busy_d;

    logic                press_ok;
    logic [SCORE_W:0]    score_sum;
    logic [POS_W-1:0]    pick_pos;
    logic [TILE_W-1:0]   pick_val;
    logic                pick_none;

    game2048_spawn_pick u_pick (
        .lfsr_i       (lfsr_q[7:0]),
        .empty_mask_i (empty_mask),
        .pos_o        (pick_pos),
        .val_o        (pick_val),
        .none_o       (pick_none)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            lfsr_q       <= LFSR_SEED;
            dir_prev_q   <= '0;
            init_cnt_q   <= '0;
            from_init_q  <= 1'b0;
            move_valid_q <= 1'b0;
            move_dir_q   <= DIR_UP;
            spawn_req_q  <= 1'b0;
            spawn_pos_q  <= '0;
            spawn_val_q  <= '0;
            score_q      <= '0;
            gstate_q     <= GS_PLAYING;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            dir_prev_q   <= direction;
            init_cnt_q   <= init_cnt_d;
            from_init_q  <= from_init_d;
            move_valid_q <= move_valid_d;
            move_dir_q   <= move_dir_d;
            spawn_req_q  <= spawn_req_d;
            spawn_pos_q  <= spawn_pos_d;
            spawn_val_q  <= spawn_val_d;
            score_q      <= score_d;
            gstate_q     <= gstate_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        // Fibonacci taps 16,14,13,11 with a right shift: bits 0,2,3,5 feed bit 15.
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        // A press needs a clean edge from all-released; held or chorded buttons never qualify.
        press_ok     = $onehot(direction) && (dir_prev_q == 4'd0);
        score_sum    = {1'b0, score_q} + {{(SCORE_W + 1 - TILE_W){1'b0}}, merge_score};

        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        from_init_d  = from_init_q;
        move_valid_d = move_valid_q;
        move_dir_d   = move_dir_q;
        spawn_req_d  = spawn_req_q;
        spawn_pos_d  = spawn_pos_q;
        spawn_val_d  = spawn_val_q;
        score_d      = score_q;
        gstate_d     = gstate_q;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q < INIT_LIM) begin
                    from_init_d = 1'b1;
                    state_d     = ST_SPAWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (press_ok) begin
                    move_valid_d = 1'b1;
                    move_dir_d   = onehot_to_dir(direction);
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (move_ready) begin
                    move_valid_d = 1'b0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (move_done) begin
                    score_d     = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    from_init_d = 1'b0;
                    // A null move adds no tile.
                    state_d     = board_changed ? ST_SPAWN : ST_CHECK;
                end
            end
            ST_SPAWN: begin
                if (pick_none) begin
                    state_d = ST_CHECK;
                end else begin
                    spawn_req_d = 1'b1;
                    spawn_pos_d = pick_pos;
                    spawn_val_d = pick_val;
                    state_d     = ST_SREQ;
                end
            end
            ST_SREQ: begin
                if (spawn_ack) begin
                    spawn_req_d = 1'b0;
                    if (from_init_q) begin
                        init_cnt_d = init_cnt_q + 8'd1;
                        state_d    = ST_INIT;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                // Board flags have settled one cycle after the tile write; win beats lose.
                if (max_tile >= WIN_TILE) begin
                    gstate_d = GS_WON;
                    state_d  = ST_WON;
                end else if ((empty_mask == '0) && !can_merge) begin
                    gstate_d = GS_LOST;
                    state_d  = ST_LOST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WON, ST_LOST: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Registered so busy reads 0 while reset is held, then tracks the next state.
        busy_d = !((state_d == ST_IDLE) || (state_d == ST_WON) || (state_d == ST_LOST));
    end

    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;
    assign spawn_req  = spawn_req_q;
    assign spawn_pos  = spawn_pos_q;
    assign spawn_val  = spawn_val_q;
    assign score      = score_q;
    assign game_state = gstate_q;
    assign busy       = busy_q;

endmodule
